// File: rtl/dpi_pkg.sv
// dpi_pkg: shared constants and FSM state encoding for the DPI stream sequencer.
//   NUM_STREAMS  - number of flow-table entries (stream contexts)
//   SID_W        - width of a stream id (log2 of NUM_STREAMS)
//   KEY_W        - width of the flow key carried on the sop beat
//   DRAIN_CYCLES - cycles spent in DRAIN between the last data beat and eop
//   state_t      - sequencer FSM states
package dpi_pkg;
  localparam int NUM_STREAMS  = 64;
  localparam int SID_W        = 6;
  localparam int KEY_W        = 16;
  localparam int DRAIN_CYCLES = 4;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);
  typedef enum logic [2:0] {IDLE, LOOKUP, LOAD, STREAM, DRAIN, EOP} state_t;
endpackage

// File: rtl/dpi_flow_table.sv
// dpi_flow_table: fully associative flow-key table with round-robin allocation.
//   clk, rst_n - clock, synchronous active-low reset (clears valid bits and pointer)
//   lookup     - high for the single LOOKUP cycle; a miss allocates an entry at the edge
//   key        - flow key being looked up
//   hit        - key matches a valid entry
//   sid        - matching index on hit, allocation pointer on miss
module dpi_flow_table
  import dpi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup,
  input  logic [KEY_W-1:0] key,
  output logic             hit,
  output logic [SID_W-1:0] sid
);
  logic [KEY_W-1:0]       keys [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid;
  logic [SID_W-1:0]       ptr;
  logic                   alloc;
  // Entries are only allocated on a miss, so at most one valid entry can match.
  always_comb begin
    hit = 1'b0;
    sid = ptr;
    for (int i = 0; i < NUM_STREAMS; i++)
      if (valid[i] && keys[i] == key) begin
        hit = 1'b1;
        sid = SID_W'(i);
      end
  end
  assign alloc = lookup && !hit;
  always_ff @(posedge clk)
    if (alloc) keys[ptr] <= key;
  // The pointer wraps naturally at NUM_STREAMS; the oldest allocation is evicted.
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid <= '0;
      ptr   <= '0;
    end else if (alloc) begin
      valid[ptr] <= 1'b1;
      ptr        <= ptr + 1'b1;
    end
endmodule

// File: rtl/dpi_stream_sequencer.sv
// dpi_stream_sequencer: maps packets to per-flow stream contexts and feeds bytes to regex matchers.
//   clk, rst_n              - clock, synchronous active-low reset
//   pkt_vld/pkt_rdy         - packet beat handshake; pkt_sop/pkt_eop frame the packet
//   pkt_data, pkt_key       - beat byte; flow key valid on the sop beat
//   cfg_we/cfg_addr/cfg_mask- per-stream matcher enable write
//   cfg_dflt_mask           - enable mask given to newly allocated streams
//   load_state              - 1-cycle pulse: stream_id/new_stream_id/enable valid
//   char_in/char_in_vld     - registered byte stream to the matchers
//   eop                     - 1-cycle end-of-packet pulse after the drain window
//   err_sop                 - sticky: a second sop arrived inside a packet
//   pkt_count/drop_count    - completed packets / orphan beats dropped in IDLE
// Build option: define DPI_SEQ_STATS_EN to compile in the counters; otherwise they read 0.
module dpi_stream_sequencer
  import dpi_pkg::*;
#(
  parameter int NUM_REGEX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_vld,
  output logic                 pkt_rdy,
  input  logic                 pkt_sop,
  input  logic                 pkt_eop,
  input  logic [7:0]           pkt_data,
  input  logic [KEY_W-1:0]     pkt_key,
  input  logic                 cfg_we,
  input  logic [SID_W-1:0]     cfg_addr,
  input  logic [NUM_REGEX-1:0] cfg_mask,
  input  logic [NUM_REGEX-1:0] cfg_dflt_mask,
  output logic                 load_state,
  output logic [SID_W-1:0]     stream_id,
  output logic                 new_stream_id,
  output logic [NUM_REGEX-1:0] enable,
  output logic [7:0]           char_in,
  output logic                 char_in_vld,
  output logic                 eop,
  output logic                 err_sop,
  output logic [31:0]          pkt_count,
  output logic [31:0]          drop_count
);
  state_t               state;
  logic [KEY_W-1:0]     key_r;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 first_beat;
  logic                 hit;
  logic [SID_W-1:0]     sid;
  logic                 lookup;
  logic                 alloc;
  logic                 accept;
  logic [NUM_REGEX-1:0] mask [NUM_STREAMS];

  assign lookup  = state == LOOKUP;
  assign alloc   = lookup && !hit;
  assign accept  = state == STREAM && pkt_vld;
  // The sop beat is held in IDLE so it can be replayed as data once the stream is loaded.
  assign pkt_rdy = state == STREAM || (state == IDLE && !pkt_sop);

  dpi_flow_table u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .lookup (lookup),
    .key    (key_r),
    .hit    (hit),
    .sid    (sid)
  );

  // Allocation is ordered after the config write so the default mask wins a same-entry collision.
  always_ff @(posedge clk) begin
    if (cfg_we) mask[cfg_addr] <= cfg_mask;
    if (alloc) mask[sid] <= cfg_dflt_mask;
  end

  always_ff @(posedge clk)
    if (accept) char_in <= pkt_data;

  always_ff @(posedge clk)
    if (!rst_n) begin
      state         <= IDLE;
      key_r         <= '0;
      drain_cnt     <= '0;
      first_beat    <= 1'b0;
      stream_id     <= '0;
      new_stream_id <= 1'b0;
      enable        <= '0;
      load_state    <= 1'b0;
      char_in_vld   <= 1'b0;
      eop           <= 1'b0;
      err_sop       <= 1'b0;
    end else begin
      load_state  <= 1'b0;
      eop         <= 1'b0;
      char_in_vld <= accept;
      case (state)
        IDLE:
          if (pkt_vld && pkt_sop) begin
            key_r <= pkt_key;
            state <= LOOKUP;
          end
        LOOKUP: begin
          stream_id     <= sid;
          new_stream_id <= !hit;
          enable        <= hit ? mask[sid] : cfg_dflt_mask;
          load_state    <= 1'b1;
          state         <= LOAD;
        end
        LOAD: begin
          first_beat <= 1'b1;
          state      <= STREAM;
        end
        STREAM:
          if (pkt_vld) begin
            first_beat <= 1'b0;
            // The opening sop beat is legitimate; any later sop inside the packet is an error.
            if (pkt_sop && !first_beat) err_sop <= 1'b1;
            if (pkt_eop) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end
          end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) state <= EOP;
        end
        EOP: begin
          eop   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

`ifdef DPI_SEQ_STATS_EN
  logic drop;
  assign drop = state == IDLE && pkt_vld && !pkt_sop;
  always_ff @(posedge clk)
    if (!rst_n) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (state == EOP) pkt_count <= pkt_count + 1'b1;
      if (drop) drop_count <= drop_count + 1'b1;
    end
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// tb_dpi_stream_sequencer: randomized self-checking bench for dpi_stream_sequencer.
module tb_dpi_stream_sequencer;
`ifdef DPI_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_vld = 1'b0, pkt_sop = 1'b0, pkt_eop = 1'b0;
  logic        pkt_rdy;
  logic [7:0]  pkt_data = '0;
  logic [15:0] pkt_key = '0;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [7:0]  cfg_mask = '0, cfg_dflt_mask = '0;
  logic        load_state, new_stream_id, char_in_vld, eop, err_sop;
  logic [5:0]  stream_id;
  logic [7:0]  enable, char_in;
  logic [31:0] pkt_count, drop_count;

  dpi_stream_sequencer #(.NUM_REGEX(8)) dut (
    .clk(clk), .rst_n(rst_n), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_sop(pkt_sop),
    .pkt_eop(pkt_eop), .pkt_data(pkt_data), .pkt_key(pkt_key), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_dflt_mask(cfg_dflt_mask),
    .load_state(load_state), .stream_id(stream_id), .new_stream_id(new_stream_id),
    .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
    .err_sop(err_sop), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         ch_cyc[$];
  logic [7:0] ch_dat[$];
  int         eop_cnt = 0;
  always @(negedge clk) begin
    if (char_in_vld === 1'b1) begin
      ch_cyc.push_back(cyc);
      ch_dat.push_back(char_in);
    end
    if (eop === 1'b1) eop_cnt++;
  end

  // Reference model: flow table as plain arrays, round-robin eviction, expected counters.
  logic [15:0] m_key[64];
  bit          m_val[64];
  logic [7:0]  m_mask[64];
  int          m_ptr;
  bit          m_err;
  logic [31:0] m_pkts, m_drops;
  logic [7:0]  bytes_q[$];
  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    foreach (m_val[i]) m_val[i] = 0;
    m_ptr = 0; m_err = 0; m_pkts = 0; m_drops = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; pkt_vld = 0; pkt_sop = 0; pkt_eop = 0; cfg_we = 0;
    repeat (3) tick();
    rst_n = 1;
    model_reset();
  endtask

  task automatic run_pkt(input logic [15:0] key, input logic [7:0] dflt, input int max_gap,
                         input int cfg_beat, input logic [7:0] cfg_m, input bit collide,
                         input int sop_beat);
    int sid, t0, l, ecyc, n;
    bit nw, seen, eseen;
    logic [7:0] en;
    logic [31:0] exp_pk;
    n = bytes_q.size();
    sid = -1;
    for (int i = 0; i < 64; i++) if (m_val[i] && m_key[i] == key) sid = i;
    nw = sid < 0;
    if (nw) begin
      sid = m_ptr; m_key[sid] = key; m_val[sid] = 1; m_mask[sid] = dflt; m_ptr = (m_ptr + 1) % 64;
    end
    en = m_mask[sid];
    ch_cyc.delete(); ch_dat.delete();
    cfg_dflt_mask = dflt;
    pkt_vld = 1; pkt_sop = 1; pkt_eop = (n == 1); pkt_key = key; pkt_data = bytes_q[0];
    t0 = cyc;
    #1;
    checks++;
    if (pkt_rdy !== 1'b0) begin errors++; $display("FAIL sop_hold_rdy: pkt_rdy=%b want 0", pkt_rdy); end
    if (collide) begin
      tick();
      cfg_we = 1; cfg_addr = 6'(sid); cfg_mask = ~dflt;
      tick();
      cfg_we = 0;
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (load_state === 1'b1) begin seen = 1; break; end
      tick();
    end
    l = cyc;
    checks++;
    if (!seen || l - t0 != 2) begin
      errors++; $display("FAIL load_latency: seen=%0d cycles=%0d want 2", seen, l - t0);
    end
    if (!seen) begin pkt_vld = 0; pkt_sop = 0; pkt_eop = 0; return; end
    checks += 3;
    if (stream_id !== 6'(sid)) begin errors++; $display("FAIL load_sid: got %0d want %0d", stream_id, sid); end
    if (new_stream_id !== nw) begin errors++; $display("FAIL load_new: got %b want %b", new_stream_id, nw); end
    if (enable !== en) begin errors++; $display("FAIL load_enable: got %h want %h", enable, en); end
    tick();
    checks++;
    if (load_state !== 1'b0) begin errors++; $display("FAIL load_pulse_width: load_state=%b want 0", load_state); end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        int g;
        g = max_gap > 0 ? int'($urandom_range(max_gap, 0)) : 0;
        pkt_vld = 0; pkt_sop = 0; pkt_eop = 0;
        repeat (g) tick();
        pkt_vld = 1; pkt_sop = (i == sop_beat); pkt_eop = (i == n - 1); pkt_data = bytes_q[i];
        if (i == sop_beat) m_err = 1;
      end
      if (i == cfg_beat) begin
        cfg_we = 1; cfg_addr = 0; cfg_mask = cfg_m; m_mask[0] = cfg_m;
      end
      tick();
      cfg_we = 0;
    end
    pkt_vld = 0; pkt_sop = 0; pkt_eop = 0;
    eseen = 0;
    for (int k = 0; k < 30; k++) begin
      if (eop === 1'b1) begin eseen = 1; break; end
      tick();
    end
    ecyc = cyc;
    m_pkts++;
    exp_pk = STATS ? m_pkts : 32'd0;
    checks++;
    if (ch_cyc.size() != n) begin
      errors++; $display("FAIL char_count: got %0d bytes want %0d", ch_cyc.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (ch_dat[i] !== bytes_q[i]) begin errors++; $display("FAIL char_data[%0d]: got %h want %h", i, ch_dat[i], bytes_q[i]); end
      end
      checks += 2;
      if (ch_cyc[0] != l + 2) begin errors++; $display("FAIL first_char_cycle: got L+%0d want L+2", ch_cyc[0] - l); end
      if (!eseen || ecyc != ch_cyc[n-1] + 5) begin
        errors++; $display("FAIL eop_timing: seen=%0d eop-lastchar=%0d want 5", eseen, ecyc - ch_cyc[n-1]);
      end
    end
    checks += 4;
    if (stream_id !== 6'(sid)) begin errors++; $display("FAIL eop_sid_stable: got %0d want %0d", stream_id, sid); end
    if (enable !== en) begin errors++; $display("FAIL eop_enable_stable: got %h want %h", enable, en); end
    if (pkt_count !== exp_pk) begin errors++; $display("FAIL pkt_count: got %0d want %0d", pkt_count, exp_pk); end
    if (err_sop !== m_err) begin errors++; $display("FAIL err_sop: got %b want %b", err_sop, m_err); end
  endtask

  task automatic test_reset();
    checks += 7;
    if (load_state !== 1'b0) begin errors++; $display("FAIL rst_load_state: got %b want 0", load_state); end
    if (char_in_vld !== 1'b0) begin errors++; $display("FAIL rst_char_in_vld: got %b want 0", char_in_vld); end
    if (eop !== 1'b0) begin errors++; $display("FAIL rst_eop: got %b want 0", eop); end
    if (err_sop !== 1'b0) begin errors++; $display("FAIL rst_err_sop: got %b want 0", err_sop); end
    if (pkt_count !== 32'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
    if (drop_count !== 32'd0) begin errors++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
    if (pkt_rdy !== 1'b1) begin errors++; $display("FAIL rst_pkt_rdy_idle: got %b want 1", pkt_rdy); end
  endtask

  task automatic test_basic();
    bytes_q = '{8'h41, 8'h42, 8'h43};
    run_pkt(16'h1234, 8'h3C, 0, -1, 8'h00, 0, -1);
  endtask

  task automatic test_hit();
    bytes_q.delete();
    repeat (4) bytes_q.push_back(8'($urandom));
    run_pkt(16'h1234, 8'hFF, 2, -1, 8'h00, 0, -1);
    checks++;
    if (new_stream_id !== 1'b0 || stream_id !== 6'd0) begin
      errors++; $display("FAIL hit_reuse: sid=%0d new=%b want sid=0 new=0", stream_id, new_stream_id);
    end
  endtask

  task automatic test_drop();
    ch_cyc.delete();
    for (int b = 0; b < 2; b++) begin
      pkt_vld = 1; pkt_sop = 0; pkt_eop = 0; pkt_data = 8'($urandom);
      #1;
      checks++;
      if (pkt_rdy !== 1'b1) begin errors++; $display("FAIL drop_rdy[%0d]: got %b want 1", b, pkt_rdy); end
      tick();
      m_drops++;
    end
    pkt_vld = 0;
    repeat (2) tick();
    checks += 2;
    if (ch_cyc.size() != 0) begin errors++; $display("FAIL drop_no_char: got %0d chars want 0", ch_cyc.size()); end
    if (drop_count !== (STATS ? m_drops : 32'd0)) begin
      errors++; $display("FAIL drop_count: got %0d want %0d", drop_count, STATS ? m_drops : 32'd0);
    end
  endtask

  task automatic test_cfg_mid();
    bytes_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    run_pkt(16'h1234, 8'h00, 1, 2, 8'h05, 0, -1);
    bytes_q = '{8'h20, 8'h21};
    run_pkt(16'h1234, 8'h00, 0, -1, 8'h00, 0, -1);
    checks++;
    if (enable !== 8'h05) begin errors++; $display("FAIL cfg_next_load: enable=%h want 05", enable); end
  endtask

  task automatic test_err_sop();
    bytes_q = '{8'h61, 8'h62, 8'h63};
    run_pkt(16'h1234, 8'h00, 0, -1, 8'h00, 0, 1);
    checks++;
    if (err_sop !== 1'b1) begin errors++; $display("FAIL err_sop_set: got %b want 1", err_sop); end
  endtask

  task automatic test_collide();
    bytes_q = '{8'h99};
    run_pkt(16'h7777, 8'h5A, 0, -1, 8'h00, 1, -1);
    bytes_q = '{8'h98, 8'h97};
    run_pkt(16'h7777, 8'h00, 0, -1, 8'h00, 0, -1);
    checks++;
    if (enable !== 8'h5A) begin errors++; $display("FAIL collide_dflt_wins: enable=%h want 5a", enable); end
  endtask

  task automatic test_reset_mid();
    int e0;
    cfg_dflt_mask = 8'h11;
    pkt_vld = 1; pkt_sop = 1; pkt_eop = 0; pkt_key = 16'h1234; pkt_data = 8'h41;
    repeat (3) tick();
    pkt_sop = 0; pkt_data = 8'h42;
    tick();
    e0 = eop_cnt;
    rst_n = 0; pkt_vld = 0;
    repeat (2) tick();
    rst_n = 1;
    model_reset();
    repeat (20) tick();
    checks += 2;
    if (eop_cnt != e0) begin errors++; $display("FAIL reset_mid_no_eop: got %0d eops want 0", eop_cnt - e0); end
    if (err_sop !== 1'b0) begin errors++; $display("FAIL reset_mid_err_sop: got %b want 0", err_sop); end
    bytes_q = '{8'h55, 8'h56};
    run_pkt(16'h1234, 8'h22, 0, -1, 8'h00, 0, -1);
    checks++;
    if (new_stream_id !== 1'b1 || stream_id !== 6'd0) begin
      errors++; $display("FAIL reset_mid_realloc: sid=%0d new=%b want sid=0 new=1", stream_id, new_stream_id);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      bytes_q = '{8'($urandom)};
      run_pkt(16'h1000 + 16'(i), 8'($urandom), 0, -1, 8'h00, 0, -1);
    end
    bytes_q = '{8'hAA, 8'hBB};
    run_pkt(16'h2000, 8'h81, 0, -1, 8'h00, 0, -1);
    checks++;
    if (new_stream_id !== 1'b1 || stream_id !== 6'd0) begin
      errors++; $display("FAIL wrap_65th: sid=%0d new=%b want sid=0 new=1", stream_id, new_stream_id);
    end
    bytes_q = '{8'hCC};
    run_pkt(16'h1000, 8'h42, 0, -1, 8'h00, 0, -1);
    checks++;
    if (new_stream_id !== 1'b1 || stream_id !== 6'd1) begin
      errors++; $display("FAIL wrap_evicted_key: sid=%0d new=%b want sid=1 new=1", stream_id, new_stream_id);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 24; p++) begin
      int n;
      logic [15:0] k;
      if ($urandom_range(3, 0) == 0) begin
        cfg_we = 1; cfg_addr = 6'($urandom_range(63, 0)); cfg_mask = 8'($urandom);
        m_mask[cfg_addr] = cfg_mask;
        tick();
        cfg_we = 0;
      end
      n = $urandom_range(6, 1);
      k = 16'h5000 + 16'($urandom_range(9, 0));
      bytes_q.delete();
      for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
      run_pkt(k, 8'($urandom), 2, -1, 8'h00, 0, (n > 1 && $urandom_range(7, 0) == 0) ? 1 : -1);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_hit();
    test_drop();
    test_cfg_mid();
    test_err_sop();
    test_collide();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dpi_stream_sequencer.md
DPI_STREAM_SEQUENCER -- requirements
Module: dpi_stream_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGEX, default 8: number of downstream regex matchers, i.e. the width of the enable vector.
REQ-002 SHALL have ports: clk in 1 clock; rst_n in 1 reset, synchronous, active-low.
REQ-003 SHALL have ports: pkt_vld in 1, pkt_rdy out 1, pkt_sop in 1, pkt_eop in 1, pkt_data in 8, pkt_key in 16 (flow key, valid with the sop beat).
REQ-004 SHALL have ports: cfg_we in 1, cfg_addr in 6, cfg_mask in NUM_REGEX (per-stream enable write); cfg_dflt_mask in NUM_REGEX (mask given to newly allocated streams).
REQ-005 SHALL have ports: load_state out 1, stream_id out 6, new_stream_id out 1, enable out NUM_REGEX, char_in out 8, char_in_vld out 1, eop out 1, err_sop out 1 (sticky), pkt_count out 32, drop_count out 32.

Function
REQ-006 SHALL implement FSM states IDLE, LOOKUP, LOAD, STREAM, DRAIN, EOP.
REQ-007 IDLE SHALL latch pkt_key and go to LOOKUP when pkt_vld&&pkt_sop, without consuming the beat.
REQ-008 pkt_rdy SHALL be combinational: 1 in STREAM; 1 in IDLE when !pkt_sop (orphan beats dropped, drop_count+1 per beat); 0 otherwise.
REQ-009 LOOKUP (1 cycle) SHALL compare the key against all 64 valid table entries in parallel; hit gives sid = matching index, new=0.
REQ-010 On miss, sid SHALL be the round-robin allocation pointer, new=1, entry overwritten with the key, marked valid, its mask set to cfg_dflt_mask, and the pointer incremented mod 64.
REQ-011 LOAD SHALL pulse load_state for exactly 1 cycle with stream_id, new_stream_id and enable (mask[sid]) valid.
REQ-012 stream_id and enable SHALL stay stable from load_state through the eop cycle inclusive.
REQ-013 STREAM SHALL start the cycle after load_state; each accepted beat SHALL drive char_in=pkt_data, char_in_vld=1 one cycle later (registered), so the earliest char_in_vld is load_state+2.
REQ-014 An accepted beat with pkt_eop SHALL move the FSM to DRAIN and DRAIN SHALL last 4 cycles, so eop pulses exactly 5 cycles after that beat's char_in_vld cycle.
REQ-015 EOP SHALL pulse eop for 1 cycle, increment pkt_count, then return to IDLE; the next load_state SHALL be at least 2 cycles after eop.
REQ-016 A single beat with both pkt_sop and pkt_eop SHALL be a valid 1-byte packet.
REQ-017 A beat with pkt_sop accepted in STREAM SHALL be forwarded as data and SHALL set err_sop.
REQ-018 A cfg_we write SHALL update mask[cfg_addr] in the next cycle; a write during a packet SHALL NOT change enable until the next LOAD.
REQ-019 cfg_we to the entry being allocated in the same LOOKUP cycle: cfg_dflt_mask SHALL win.
REQ-020 Counters SHALL wrap at 2^32.

Reset
REQ-021 On rst_n=0 the block SHALL enter IDLE, clear all table valid bits, zero the allocation pointer and the counters, and clear err_sop, load_state, char_in_vld and eop.
REQ-022 Reset mid-packet SHALL abandon the packet with no eop issued.
REQ-023 The mask array and char_in SHALL NOT be reset.

Configuration
REQ-024 Macro DPI_SEQ_STATS_EN SHALL compile in pkt_count and drop_count; without it, both outputs SHALL be constant 0 and the counter logic removed.

Structure
REQ-025 Package dpi_pkg SHALL hold NUM_STREAMS=64, SID_W=6, KEY_W=16, DRAIN_CYCLES=4 and the FSM state enum.
REQ-026 Sub-module dpi_flow_table SHALL hold the key/valid CAM, the allocation pointer and the hit/miss/sid result.

Verification
REQ-027 Key 0x1234 sop, 3 bytes "ABC" with eop on C -> load_state with sid=0, new=1; char_in A,B,C on L+2..L+4; eop at L+9.
REQ-028 The same key 0x1234 again -> sid=0, new=0, enable=mask[0].
REQ-029 65 distinct keys -> 65th gets sid=0, new=1 (wrap), and key of entry 0 replaced.
REQ-030 Two non-sop beats in IDLE -> pkt_rdy=1, no char_in_vld, drop_count=2.
REQ-031 cfg_we addr 0 mask 0x05 mid-packet -> enable unchanged until the next packet's load_state shows 0x05.
REQ-032 rst_n low during STREAM -> no eop; the next packet with a prior key gets new=1.
